// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: the single memory port that mem_arbiter drives.
//
// Handshake: the master raises mem_valid with mem_write/mem_addr/mem_wdata/
// mem_byte_en and holds all of them stable until a cycle in which the slave
// drives mem_ready=1. That cycle both accepts and completes the transaction;
// for reads mem_rdata is valid only in that cycle. mem_ready is ignored while
// mem_valid=0.
//
// Signals:
//   mem_valid   master->slave  transaction active
//   mem_write   master->slave  1 = store, 0 = load/fetch
//   mem_addr    master->slave  byte address
//   mem_wdata   master->slave  store data
//   mem_byte_en master->slave  byte enables (all ones for reads)
//   mem_ready   slave->master  transaction completes this cycle
//   mem_rdata   slave->master  read data, valid with mem_ready
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    mem_valid;
  logic                    mem_write;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_byte_en;
  logic                    mem_ready;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_valid, mem_write, mem_addr, mem_wdata, mem_byte_en,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_write, mem_addr, mem_wdata, mem_byte_en,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data
// access. One transaction is outstanding at a time; simultaneous requests are
// granted round-robin. Completion is reported with a one-cycle done pulse and
// registered read data. Fetches can be cancelled (bus cycle still completes,
// result dropped). A watchdog ends a transaction that waits too long for
// mem_ready and raises a sticky bus_error.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr/if_cancel fetch request (level), address, flush cancel
//   if_rdata/if_done         fetched word and its completion pulse
//   dm_req/dm_write/dm_addr/dm_wdata/dm_byte_en  data request
//   dm_rdata/dm_done         load data and its completion pulse
//   bus                      memory port (mem_arbiter_if master)
//   busy                     a transaction is in flight
//   bus_error                sticky watchdog timeout flag
//   state_dbg                current FSM state (0 IDLE, 1 FETCH, 2 DATA)
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_cancel,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_done,
  input  logic                    dm_req,
  input  logic                    dm_write,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_byte_en,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_done,
  mem_arbiter_if.master           bus,
  output logic                    busy,
  output logic                    bus_error,
  output logic [1:0]              state_dbg
);

  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic LG_FETCH = 1'b0;
  localparam logic LG_DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q;
  logic                    discard_q;
  logic [CNT_W-1:0]        wait_cnt_q;
  logic                    bus_error_q;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] byte_en_q;
  logic [DATA_WIDTH-1:0]   if_rdata_q, dm_rdata_q;
  logic                    if_done_q, dm_done_q;

  logic elig_if, grant_if, grant_dm, finish, timeout;

  always_comb begin
    state_d  = state_q;
    elig_if  = if_req && !if_cancel;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    finish   = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        // Data wins when it is the only eligible request, or on a tie when
        // fetch had the previous grant.
        if (dm_req && (!elig_if || last_grant_q == LG_FETCH)) begin
          grant_dm = 1'b1;
          state_d  = DATA;
        end else if (elig_if) begin
          grant_if = 1'b1;
          state_d  = FETCH;
        end
      end
      FETCH, DATA: begin
        if (bus.mem_ready) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else if (wait_cnt_q == CNT_W'(WAIT_LIMIT)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= LG_FETCH;
      discard_q    <= 1'b0;
      wait_cnt_q   <= '0;
      bus_error_q  <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      byte_en_q    <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;

      if (grant_dm) begin
        addr_q       <= dm_addr;
        wdata_q      <= dm_wdata;
        byte_en_q    <= dm_write ? dm_byte_en : '1;
        write_q      <= dm_write;
        last_grant_q <= LG_DATA;
        wait_cnt_q   <= '0;
      end else if (grant_if) begin
        addr_q       <= if_addr;
        wdata_q      <= '0;
        byte_en_q    <= '1;
        write_q      <= 1'b0;
        last_grant_q <= LG_FETCH;
        wait_cnt_q   <= '0;
      end

      if (finish || timeout) begin
        // A timed-out transaction reports zero data.
        discard_q <= 1'b0;
        if (state_q == FETCH) begin
          if_rdata_q <= finish ? bus.mem_rdata : '0;
          if_done_q  <= !(discard_q || if_cancel);
        end else begin
          dm_rdata_q <= finish ? bus.mem_rdata : '0;
          dm_done_q  <= 1'b1;
        end
      end else if (state_q != IDLE) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        if (state_q == FETCH && if_cancel) discard_q <= 1'b1;
      end

      if (timeout) bus_error_q <= 1'b1;
    end
  end

  assign bus.mem_valid   = (state_q != IDLE);
  assign bus.mem_write   = write_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_byte_en = byte_en_q;

  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_done   = dm_done_q;
  assign busy      = (state_q != IDLE);
  assign bus_error = bus_error_q;
  assign state_dbg = state_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port between the instruction-fetch stage and the memory-access stage of the pipelined CPU. It serialises one outstanding transaction at a time and arbitrates round-robin when both stages request together. It returns read data with a one-cycle done pulse that feeds the pipeline controller's `fetch_done` / `mem_done` inputs. Fetch transactions can be cancelled on a branch flush; the bus cycle still completes but its result is dropped. A watchdog flags a hung memory.

## Interface
- `DATA_WIDTH`, 32, data bus width
- `ADDR_WIDTH`, 32, byte address width
- `WAIT_LIMIT`, 255, maximum cycles to wait for `mem_ready` before timeout (≥1)

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch read request, level, held until `if_done`
- `if_addr`  in  ADDR_WIDTH  fetch address
- `if_cancel`  in  1  drop current/pending fetch (branch flush)
- `if_rdata`  out  DATA_WIDTH  fetched word, valid while `if_done`=1
- `if_done`  out  1  one-cycle completion pulse
- `dm_req`  in  1  data request, level, held until `dm_done`
- `dm_write`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_WIDTH  data address
- `dm_wdata`  in  DATA_WIDTH  store data
- `dm_byte_en`  in  DATA_WIDTH/8  store byte enables
- `dm_rdata`  out  DATA_WIDTH  load data, valid while `dm_done`=1
- `dm_done`  out  1  one-cycle completion pulse
- `mem_valid`  out  1  transaction active on memory port
- `mem_write`  out  1  store when 1
- `mem_addr`  out  ADDR_WIDTH  address
- `mem_wdata`  out  DATA_WIDTH  store data
- `mem_byte_en`  out  DATA_WIDTH/8  byte enables; all ones for reads
- `mem_ready`  in  1  memory accepts/completes in this cycle
- `mem_rdata`  in  DATA_WIDTH  read data, valid when `mem_ready`=1
- `busy`  out  1  state ≠ IDLE
- `bus_error`  out  1  sticky timeout flag

## Operation
- **States:** IDLE, FETCH, DATA.
- **Grant in IDLE:**
  - Eligible requests are `dm_req` and (`if_req` && !`if_cancel`).
  - With one eligible request, grant it.
  - With both eligible, grant the one not equal to `last_grant`.
  - On grant, latch addr/wdata/byte_en/write into output registers, set `last_grant`, clear the wait counter, and enter FETCH or DATA.
- **Memory port:**
  - `mem_valid` = (state ≠ IDLE).
  - Outputs stay stable until a cycle with `mem_ready`=1.
  - Fetch grants drive `mem_write`=0 and `mem_byte_en`=all ones.
- **Completion:** a cycle in FETCH/DATA with `mem_ready`=1 does the following:
  - Register `mem_rdata` into `if_rdata`/`dm_rdata`.
  - Pulse the matching done next cycle. For FETCH, no pulse if `discard` is set or `if_cancel`=1 this cycle.
  - Return to IDLE and clear `discard`.
- **Cancel:**
  - `if_cancel` in FETCH sets `discard`; the memory transaction still completes.
  - `if_cancel` never affects DATA.
- **Watchdog:**
  - The counter increments each FETCH/DATA cycle without `mem_ready`.
  - On reaching `WAIT_LIMIT`:
    - set `bus_error`;
    - pulse the owning done with rdata = 0 (fetch pulse suppressed if discarded);
    - go to IDLE.
  - `bus_error` clears only on `rst`.
- **Request sampling:** requests are sampled only in IDLE. A requester still asserting req in its done cycle is issuing a new request.
- **Reset:**
  - All outputs 0.
  - state = IDLE, `last_grant` = FETCH (data wins the first tie).
  - `discard` = 0, counter = 0.
  - Reset mid-transaction abandons it with no done pulse.

## Timing
- Zero-wait memory gives request → done = 2 cycles:
  - cycle n: IDLE, req seen;
  - cycle n+1: `mem_valid`, `mem_ready`;
  - cycle n+2: done, rdata valid.
- Each memory wait cycle adds 1 cycle.
- Back-to-back transactions: one IDLE cycle between them (the done cycle), so peak throughput is 1 transaction per 2 cycles.
- done is high exactly one cycle; rdata holds until the next completion of the same port.
- Timeout: done fires `WAIT_LIMIT`+1 cycles after `mem_valid` rises.

## Test plan
- **Single fetch:** `if_req`=1, `if_addr`=0x0000_0040, `mem_ready` tied 1, `mem_rdata`=0x2402_0005.
  - Required: `mem_valid` high exactly 1 cycle with `mem_addr`=0x40, `mem_write`=0.
  - Required: `if_done` 2 cycles after req, with `if_rdata`=0x2402_0005.
- **Contention:** `if_req` and `dm_req` (store 0xDEAD_BEEF to 0x100, byte_en=0xF) asserted together and held.
  - Required: DATA granted first, then FETCH, and the order alternates while both remain asserted.
- **Cancel mid-flight:** fetch granted, memory stalls 3 cycles, `if_cancel` pulsed in the 2nd wait cycle.
  - Required: bus transaction completes and `if_done` stays 0.
  - Required: a following `dm_req` is granted in the next IDLE cycle.
- **Cancel in IDLE with `dm_req` low:** `if_req`=1, `if_cancel`=1.
  - Required: no grant; `mem_valid` stays 0.
- **Timeout:** `WAIT_LIMIT`=4, `dm_req` load, `mem_ready` held 0.
  - Required: `dm_done` pulses with `dm_rdata`=0 and `bus_error` rises.
  - Required: `bus_error` stays high until `rst`.
- **Reset mid-transaction:** assert `rst` while in DATA.
  - Required: next cycle `mem_valid`=0, `busy`=0, no done pulse.
  - Required: the next tie after reset is granted to data.
